// File: rtl/accu_op_sequencer.sv
// accu_op_sequencer: queues accumulator commands and replays each one as rpt+1 clock-enabled cycles, then returns the captured result.
// Optional macro SEQ_CY_STOP_EN: a raised carry ends a command's burst early.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef OP_CODE_WIDTH
`define OP_CODE_WIDTH 4
`endif

module accu_op_sequencer #(
  parameter int data_width    = `DATA_WIDTH,
  parameter int op_code_width = `OP_CODE_WIDTH,
  parameter int fifo_depth    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [op_code_width-1:0] cmd_op,
  input  logic [data_width-1:0]    cmd_data,
  input  logic [3:0]               cmd_rpt,
  output logic [op_code_width-1:0] opcode,
  output logic                     acc_ce,
  output logic [data_width-1:0]    data_out,
  input  logic [data_width-1:0]    acc_data,
  input  logic                     acc_cy,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [data_width-1:0]    res_data,
  output logic                     res_cy,
  output logic [4:0]               res_cnt,
  output logic                     busy
);
  localparam int aw = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int cw = aw + 1;
  localparam logic [cw-1:0] cnt_full = cw'(fifo_depth);

  typedef enum logic [2:0] {IDLE, LOAD, EXEC, CAPT, RESP} state_t;
  state_t state;

  logic [op_code_width-1:0] q_op   [fifo_depth];
  logic [data_width-1:0]    q_data [fifo_depth];
  logic [3:0]               q_rpt  [fifo_depth];
  logic [aw-1:0]            wr_ptr, rd_ptr;
  logic [cw-1:0]            count;
  logic                     push, pop, cy_stop, ce_q;
  logic [3:0]               remaining;
  logic [4:0]               issued;

  // Full is judged on the registered count only, so a same-cycle pop never reopens the queue.
  assign cmd_ready = (count != cnt_full);
  assign push      = cmd_valid & cmd_ready;
  assign pop       = (state == LOAD);
  assign busy      = (state != IDLE) | (count != '0);

`ifdef SEQ_CY_STOP_EN
  assign cy_stop = (issued != 5'd0) & acc_cy;
`else
  assign cy_stop = 1'b0;
`endif
  assign acc_ce = ce_q & ~cy_stop;

  always_ff @(posedge clk) begin
    if (push) begin
      q_op[wr_ptr]   <= cmd_op;
      q_data[wr_ptr] <= cmd_data;
      q_rpt[wr_ptr]  <= cmd_rpt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ce_q      <= 1'b0;
      opcode    <= '0;
      data_out  <= '0;
      remaining <= '0;
      issued    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_cy    <= 1'b0;
      res_cnt   <= '0;
    end else begin
      // Pointers wrap naturally because the depth is a power of two.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      case (state)
        IDLE: if (count != '0) state <= LOAD;
        LOAD: begin
          opcode    <= q_op[rd_ptr];
          data_out  <= q_data[rd_ptr];
          remaining <= q_rpt[rd_ptr];
          issued    <= '0;
          ce_q      <= 1'b1;
          state     <= EXEC;
        end
        EXEC: begin
          if (cy_stop) begin
            ce_q  <= 1'b0;
            state <= CAPT;
          end else begin
            issued <= issued + 1'b1;
            if (remaining == 4'd0) begin
              ce_q  <= 1'b0;
              state <= CAPT;
            end else begin
              remaining <= remaining - 1'b1;
            end
          end
        end
        CAPT: begin
          res_data  <= acc_data;
          res_cy    <= acc_cy;
          res_cnt   <= issued;
          res_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= (count != '0) ? LOAD : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_accu_op_sequencer.sv
// Bench for accu_op_sequencer: transaction-level model with a per-cycle compare process plus directed timing scenarios.
module tb_accu_op_sequencer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [3:0] cmd_op = '0;
  logic [7:0] cmd_data = '0;
  logic [3:0] cmd_rpt = '0;
  logic       res_ready = 1'b0;
  logic       cmd_ready, acc_ce, res_valid, res_cy, busy, acc_cy;
  logic [3:0] opcode;
  logic [7:0] data_out, acc_data, res_data;
  logic [4:0] res_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  accu_op_sequencer #(.data_width(8), .op_code_width(4), .fifo_depth(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_rpt(cmd_rpt),
    .opcode(opcode), .acc_ce(acc_ce), .data_out(data_out),
    .acc_data(acc_data), .acc_cy(acc_cy),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_cy(res_cy), .res_cnt(res_cnt),
    .busy(busy)
  );

  // Accumulator behaviour: 0 = load, 3 = add with carry out, 5 = xor, others hold.
  function automatic logic [8:0] alu(input logic [3:0] op, input logic [7:0] d, input logic [7:0] a);
    case (op)
      4'd0:    alu = {1'b0, d};
      4'd3:    alu = {1'b0, a} + {1'b0, d};
      4'd5:    alu = {1'b0, a ^ d};
      default: alu = {1'b0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      acc_data <= '0;
      acc_cy   <= 1'b0;
    end else if (acc_ce) begin
      {acc_cy, acc_data} <= alu(opcode, data_out, acc_data);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model + compare process ----------------
  typedef struct packed {
    logic [3:0] op;
    logic [7:0] data;
    logic [3:0] rpt;
  } cmd_t;

  cmd_t       mq[$];
  cmd_t       cur;
  bit         active = 0;
  bit         rv_seen = 0;
  int         exp_n, ce_seen;
  int         n_results = 0;
  logic [7:0] m_acc = '0;
  logic       m_cy = 1'b0;
  logic [7:0] exp_data, snap_data;
  logic       exp_cy, snap_cy;
  logic [4:0] snap_cnt;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      active  = 0;
      rv_seen = 0;
      m_acc   = '0;
      m_cy    = 1'b0;
    end else begin
      chk("busy", busy, active || mq.size() != 0);
      if (acc_ce) begin
        if (!active) begin
          chk("ce_has_cmd", mq.size() != 0, 1);
          if (mq.size() != 0) begin
            cur = mq.pop_front();
            exp_n = 0;
            for (int k = 0; k <= int'(cur.rpt); k++) begin
              {m_cy, m_acc} = alu(cur.op, cur.data, m_acc);
              exp_n++;
`ifdef SEQ_CY_STOP_EN
              if (m_cy) break;
`endif
            end
            exp_data = m_acc;
            exp_cy   = m_cy;
            active   = 1;
            ce_seen  = 0;
          end
        end
        if (active) begin
          chk("ce_opcode", opcode, cur.op);
          chk("ce_data_out", data_out, cur.data);
          chk("ce_within_count", ce_seen < exp_n, 1);
          ce_seen++;
        end
        chk("ce_during_resp", res_valid, 0);
      end
      if (res_valid) begin
        chk("res_has_cmd", active, 1);
        if (!rv_seen) begin
          chk("res_data", res_data, exp_data);
          chk("res_cy", res_cy, exp_cy);
          chk("res_cnt", res_cnt, exp_n);
          chk("ce_total", ce_seen, exp_n);
          snap_data = res_data;
          snap_cy   = res_cy;
          snap_cnt  = res_cnt;
          rv_seen   = 1;
          n_results++;
        end else begin
          chk("res_data_stable", res_data, snap_data);
          chk("res_cy_stable", res_cy, snap_cy);
          chk("res_cnt_stable", res_cnt, snap_cnt);
        end
        if (res_ready) begin
          active  = 0;
          rv_seen = 0;
        end
      end
      if (cmd_valid && cmd_ready) mq.push_back('{op: cmd_op, data: cmd_data, rpt: cmd_rpt});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic [3:0] op, input logic [7:0] d, input logic [3:0] r);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_rpt = r;
    chk("push_ready", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rv(input int budget);
    int n = 0;
    while (!res_valid && n < budget) begin tick(); n++; end
    chk("wait_res_valid", res_valid, 1);
  endtask

  initial begin
    logic [6:0] ce_pat = 7'b0011100;
    logic [6:0] rv_pat = 7'b1000000;
    int n, r0, n_ce, cyc;

    // Reset and idle.
    rst = 1'b1;
    tick(); tick();
    chk("rst_acc_ce", acc_ce, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_cy", res_cy, 0);
    chk("rst_res_cnt", res_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_acc_ce", acc_ce, 0);
      chk("idle_cmd_ready", cmd_ready, 1);
    end

    // op=3 data=5A rpt=2: ce in t+2..t+4, result at t+6 = 5A*3 = 10E.
    push_cmd(4'd3, 8'h5A, 4'd2);
    for (int i = 0; i < 7; i++) begin
      if (i > 0) tick();
      chk("lat_acc_ce", acc_ce, ce_pat[i]);
      chk("lat_res_valid", res_valid, rv_pat[i]);
      if (ce_pat[i]) begin
        chk("lat_opcode", opcode, 4'd3);
        chk("lat_data_out", data_out, 8'h5A);
      end
    end
    chk("lit_res_cnt", res_cnt, 5'd3);
    chk("lit_res_data", res_data, 8'h0E);
    chk("lit_res_cy", res_cy, 1);
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    chk("after_ack_res_valid", res_valid, 0);
    chk("hold_opcode", opcode, 4'd3);
    chk("hold_data_out", data_out, 8'h5A);

    // One command parked in RESP, then fill the queue behind it.
    r0 = n_results;
    push_cmd(4'd0, 8'h11, 4'd0);
    wait_rv(10);
    chk("lit_load_data", res_data, 8'h11);
    chk("lit_load_cnt", res_cnt, 5'd1);
    push_cmd(4'd3, 8'h22, 4'd1);
    push_cmd(4'd5, 8'hFF, 4'd0);
    push_cmd(4'd3, 8'hF0, 4'd2);
    push_cmd(4'd0, 8'h07, 4'd3);
    chk("full_cmd_ready", cmd_ready, 0);
    cmd_valid = 1'b1; cmd_op = 4'd6; cmd_data = 8'h33; cmd_rpt = 4'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_cmd_ready", cmd_ready, 0);
      chk("hold_acc_ce", acc_ce, 0);
      chk("hold_res_valid", res_valid, 1);
    end
    res_ready = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    chk("stall_cycles", n, 2);
    tick();
    cmd_valid = 1'b0;
    n = 0;
    while (busy && n < 300) begin tick(); n++; end
    chk("drained", busy, 0);
    chk("results_returned", n_results - r0, 6);
    res_ready = 1'b0;

    // Reset in the second EXEC cycle of rpt=7, with a push racing the reset edge.
    push_cmd(4'd3, 8'h01, 4'd7);
    tick(); tick(); tick();
    chk("exec2_acc_ce", acc_ce, 1);
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_op = 4'd3; cmd_data = 8'h44; cmd_rpt = 4'd0;
    tick();
    rst = 1'b0;
    cmd_valid = 1'b0;
    chk("abort_acc_ce", acc_ce, 0);
    chk("abort_res_valid", res_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("abort_no_res", res_valid, 0);
      chk("abort_no_ce", acc_ce, 0);
    end

    // Carry-stop scenario from a cleared accumulator: 0x90 per ce, carry after the 2nd.
    push_cmd(4'd3, 8'h90, 4'd15);
    n_ce = 0; cyc = 0;
    while (!res_valid && cyc < 40) begin
      if (acc_ce) n_ce++;
      tick();
      cyc++;
    end
    chk("cs_res_valid", res_valid, 1);
    chk("cs_res_cy", res_cy, 1);
`ifdef SEQ_CY_STOP_EN
    chk("cs_ce_count", n_ce, 2);
    chk("cs_res_cnt", res_cnt, 5'd2);
    chk("cs_res_data", res_data, 8'h20);
    chk("cs_latency", cyc, 6);
`else
    chk("cs_ce_count", n_ce, 16);
    chk("cs_res_cnt", res_cnt, 5'd16);
    chk("cs_res_data", res_data, 8'h00);
    chk("cs_latency", cyc, 19);
`endif
    res_ready = 1'b1; tick(); res_ready = 1'b0;
    tick(); tick();
    chk("end_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
